mainfsm_ws: RTL and testbench

MAINFSM_WS -- requirements
Module: mainfsm_ws

---
 rtl/mainfsm_ws.sv | 242 ++++++++++++++++++++++++
 tb/tb_mainfsm_ws.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mainfsm_ws.sv
// Multicycle RISC-V main control FSM with memory wait states, a wait timeout,
// external stall and an absorbing trap state.
module mainfsm_ws #(
  parameter int unsigned TO_W   = 4,
  parameter int unsigned TO_MAX = 15,
  parameter bit          EN_LUI = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  input  logic       stall,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic       mem_req,
  output logic       mem_rd,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWrite = 4'd4,
    StMemWb    = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StAuipc    = 4'd11,
    StLui      = 4'd12,
    StTrap     = 4'd13
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  localparam logic [TO_W-1:0] ToLimit = TO_W'(TO_MAX);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            is_wait;
  logic            hold;

  assign is_wait = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign hold    = stall && !is_wait && (state_q != StTrap);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      StFetch: begin
        if (mem_ready) begin
          state_d = StDecode;
        end else if (cnt_q == ToLimit) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StDecode: begin
        case (op)
          OpLoad, OpStore, OpJalr: state_d = StMemAdr;
          OpRtype:                 state_d = StExecR;
          OpItype:                 state_d = StExecI;
          OpBranch:                state_d = StBranch;
          OpJal:                   state_d = StJal;
          OpAuipc:                 state_d = StAuipc;
          OpLui: begin
            if (EN_LUI) begin
              state_d = StLui;
            end else begin
              state_d = StTrap;
              cause_d = CauseIllegal;
            end
          end
          default: begin
            state_d = StTrap;
            cause_d = CauseIllegal;
          end
        endcase
      end
      StMemAdr: begin
        if (op == OpJalr)  state_d = StJal;
        else if (op[5])    state_d = StMemWrite;
        else               state_d = StMemRead;
      end
      StMemRead: begin
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (cnt_q == ToLimit) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StMemWrite: begin
        if (mem_ready) begin
          state_d = StFetch;
        end else if (cnt_q == ToLimit) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StExecR, StExecI, StAuipc, StLui, StJal: state_d = StAluWb;
      StMemWb, StAluWb, StBranch:              state_d = StFetch;
      StTrap:                                  state_d = StTrap;
      default:                                 state_d = StFetch;
    endcase
    if (hold) begin
      state_d = state_q;
      cause_d = cause_q;
    end
  end

  // Counter runs only while a wait state holds; any state change clears it.
  always_comb begin
    cnt_d = '0;
    if (is_wait && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 2'b00;
    mem_req   = 1'b0;
    mem_rd    = 1'b0;
    trap      = 1'b0;
    case (state_q)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        mem_req   = 1'b1;
        mem_rd    = 1'b1;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        mem_req = 1'b1;
        mem_rd  = 1'b1;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        mem_req  = 1'b1;
        MemWrite = mem_ready;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb: RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
      end
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
      end
      StAuipc: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StLui: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      StTrap:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
    if (hold) begin
      RegWrite = 1'b0;
      PCUpdate = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mainfsm_ws.sv
// Scoreboard bench for mainfsm_ws: a default instance and one with LUI disabled
// share stimulus; each cycle's expected state/outputs are queued and compared.
module tb_mainfsm_ws;

  localparam logic [3:0] SF = 4'd0, SD = 4'd1, SMA = 4'd2, SMR = 4'd3, SMW = 4'd4;
  localparam logic [3:0] SWB = 4'd5, SER = 4'd6, SEI = 4'd7, SAW = 4'd8, SBR = 4'd9;
  localparam logic [3:0] SJ = 4'd10, SAU = 4'd11, SLU = 4'd12, STR = 4'd13;

  localparam logic [6:0] OPL = 7'b0000011, OPS = 7'b0100011, OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011, OPB = 7'b1100011, OPJ = 7'b1101111;
  localparam logic [6:0] OPJR = 7'b1100111, OPA = 7'b0010111, OPU = 7'b0110111;
  localparam logic [6:0] OPX = 7'b1111111;

  typedef struct packed {
    logic [3:0] s1;
    logic [1:0] c1;
    logic [3:0] s2;
    logic [1:0] c2;
    logic       rdy;
    logic       stl;
    logic [6:0] op;
  } row_t;

  typedef struct packed {
    logic [22:0] e1;
    logic [22:0] e2;
  } exp_t;

  logic       clk, rst_n, mem_ready, stall;
  logic [6:0] op;

  logic [1:0] a_srca, a_srcb, a_res, a_aluop, a_cause;
  logic       a_adr, a_irw, a_pcu, a_rw, a_mw, a_br, a_req, a_rd, a_trap;
  logic [3:0] a_state;
  logic [1:0] b_srca, b_srcb, b_res, b_aluop, b_cause;
  logic       b_adr, b_irw, b_pcu, b_rw, b_mw, b_br, b_req, b_rd, b_trap;
  logic [3:0] b_state;
  logic [22:0] obs1, obs2;

  int   total = 0;
  int   bad = 0;
  string tname;
  row_t  rows[$];
  exp_t  sb[$];

  mainfsm_ws dut_a (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .stall(stall),
    .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .ResultSrc(a_res), .AdrSrc(a_adr),
    .IRWrite(a_irw), .PCUpdate(a_pcu), .RegWrite(a_rw), .MemWrite(a_mw), .Branch(a_br),
    .ALUOp(a_aluop), .mem_req(a_req), .mem_rd(a_rd), .trap(a_trap), .trap_cause(a_cause),
    .state_o(a_state)
  );

  mainfsm_ws #(.TO_W(4), .TO_MAX(15), .EN_LUI(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .stall(stall),
    .ALUSrcA(b_srca), .ALUSrcB(b_srcb), .ResultSrc(b_res), .AdrSrc(b_adr),
    .IRWrite(b_irw), .PCUpdate(b_pcu), .RegWrite(b_rw), .MemWrite(b_mw), .Branch(b_br),
    .ALUOp(b_aluop), .mem_req(b_req), .mem_rd(b_rd), .trap(b_trap), .trap_cause(b_cause),
    .state_o(b_state)
  );

  assign obs1 = {a_state, a_srca, a_srcb, a_res, a_adr, a_irw, a_pcu, a_rw, a_mw, a_br,
                 a_aluop, a_req, a_rd, a_trap, a_cause};
  assign obs2 = {b_state, b_srca, b_srcb, b_res, b_adr, b_irw, b_pcu, b_rw, b_mw, b_br,
                 b_aluop, b_req, b_rd, b_trap, b_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference output table, written straight from the per-state output list.
  function automatic logic [22:0] model(input logic [3:0] st, input logic rdy, input logic stl,
                                        input logic [1:0] cause);
    logic [1:0] a, b, res, aluop;
    logic       adr, irw, pcu, rw, mw, br, req, rd, trp;
    a = 2'b00; b = 2'b00; res = 2'b00; aluop = 2'b00;
    adr = 0; irw = 0; pcu = 0; rw = 0; mw = 0; br = 0; req = 0; rd = 0; trp = 0;
    case (st)
      4'd0:  begin b = 2'b10; res = 2'b10; req = 1; rd = 1; irw = rdy; pcu = rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin adr = 1; req = 1; rd = 1; end
      4'd4:  begin adr = 1; req = 1; mw = rdy; end
      4'd5:  begin res = 2'b01; rw = 1; end
      4'd6:  begin a = 2'b10; aluop = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; aluop = 2'b10; end
      4'd8:  rw = 1;
      4'd9:  begin a = 2'b10; aluop = 2'b01; br = 1; end
      4'd10: begin a = 2'b01; b = 2'b10; pcu = 1; end
      4'd11: begin a = 2'b01; b = 2'b01; end
      4'd12: begin a = 2'b11; b = 2'b01; end
      4'd13: trp = 1;
      default: trp = 0;
    endcase
    if (stl && !(st inside {4'd0, 4'd3, 4'd4, 4'd13})) begin
      rw = 0; pcu = 0; mw = 0; irw = 0;
    end
    return {st, a, b, res, adr, irw, pcu, rw, mw, br, aluop, req, rd, trp, cause};
  endfunction

  function automatic row_t r(input logic [3:0] s, input logic [1:0] c, input logic rdy,
                             input logic stl, input logic [6:0] o);
    return '{s1: s, c1: c, s2: s, c2: c, rdy: rdy, stl: stl, op: o};
  endfunction

  function automatic row_t r2(input logic [3:0] s1, input logic [1:0] c1, input logic [3:0] s2,
                              input logic [1:0] c2, input logic [6:0] o);
    return '{s1: s1, c1: c1, s2: s2, c2: c2, rdy: 1'b1, stl: 1'b0, op: o};
  endfunction

  // Drives one cycle's inputs and queues what both instances should show.
  task automatic apply(input row_t rw);
    exp_t e;
    mem_ready = rw.rdy;
    stall     = rw.stl;
    op        = rw.op;
    e.e1 = model(rw.s1, rw.rdy, rw.stl, rw.c1);
    e.e2 = model(rw.s2, rw.rdy, rw.stl, rw.c2);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tname = "reset";
    rst_n = 1'b0; op = OPX; stall = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      mem_ready = i[0];
      #1;
      total++;
      if (obs1 !== model(SF, i[0], 1'b0, 2'b00)) begin
        bad++; $display("FAIL reset_out rdy=%0d main got=%h exp=%h", i, obs1, model(SF, i[0], 1'b0, 2'b00));
      end
      total++;
      if (obs2 !== model(SF, i[0], 1'b0, 2'b00)) begin
        bad++; $display("FAIL reset_out rdy=%0d nolui got=%h exp=%h", i, obs2, model(SF, i[0], 1'b0, 2'b00));
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    exp_t e;
    tname = "rtype";
    do_reset();
    rows.delete();
    rows.push_back(r(SF, 0, 1, 0, OPR)); rows.push_back(r(SD, 0, 1, 0, OPR));
    rows.push_back(r(SER, 0, 1, 0, OPR)); rows.push_back(r(SAW, 0, 1, 0, OPR));
    rows.push_back(r(SF, 0, 1, 0, OPR));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    tname = "load_wait";
    do_reset();
    rows.delete();
    rows.push_back(r(SF, 0, 1, 0, OPL)); rows.push_back(r(SD, 0, 1, 0, OPL));
    rows.push_back(r(SMA, 0, 1, 0, OPL));
    for (int k = 0; k < 3; k++) rows.push_back(r(SMR, 0, 0, k[0], OPL));
    rows.push_back(r(SMR, 0, 1, 0, OPL)); rows.push_back(r(SWB, 0, 1, 0, OPL));
    rows.push_back(r(SF, 0, 1, 0, OPL));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_stall();
    exp_t e;
    tname = "store_stall";
    do_reset();
    rows.delete();
    rows.push_back(r(SF, 0, 1, 1, OPS));  rows.push_back(r(SD, 0, 1, 1, OPS));
    rows.push_back(r(SD, 0, 1, 0, OPS));  rows.push_back(r(SMA, 0, 1, 0, OPS));
    rows.push_back(r(SMW, 0, 0, 1, OPS)); rows.push_back(r(SMW, 0, 1, 1, OPS));
    rows.push_back(r(SF, 0, 0, 0, OPS));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    for (int pass = 0; pass < 3; pass++) begin
      do_reset();
      rows.delete();
      if (pass == 0) begin
        tname = "timeout_trap";
        for (int k = 0; k < 16; k++) rows.push_back(r(SF, 0, 0, 0, OPI));
        for (int k = 0; k < 3; k++) rows.push_back(r(STR, 2'b10, 1, k[0], OPI));
      end else if (pass == 1) begin
        tname = "timeout_edge";
        for (int k = 0; k < 15; k++) rows.push_back(r(SF, 0, 0, 0, OPI));
        rows.push_back(r(SF, 0, 1, 0, OPI)); rows.push_back(r(SD, 0, 1, 0, OPI));
        rows.push_back(r(SEI, 0, 1, 0, OPI)); rows.push_back(r(SAW, 0, 1, 0, OPI));
        rows.push_back(r(SF, 0, 1, 0, OPI));
      end else begin
        tname = "timeout_clear";
        for (int k = 0; k < 10; k++) rows.push_back(r(SF, 0, 0, 0, OPL));
        rows.push_back(r(SF, 0, 1, 0, OPL)); rows.push_back(r(SD, 0, 1, 0, OPL));
        rows.push_back(r(SMA, 0, 1, 0, OPL));
        for (int k = 0; k < 15; k++) rows.push_back(r(SMR, 0, 0, 0, OPL));
        rows.push_back(r(SMR, 0, 1, 0, OPL)); rows.push_back(r(SWB, 0, 1, 0, OPL));
        rows.push_back(r(SF, 0, 1, 0, OPS)); rows.push_back(r(SD, 0, 1, 0, OPS));
        rows.push_back(r(SMA, 0, 1, 0, OPS));
        for (int k = 0; k < 16; k++) rows.push_back(r(SMW, 0, 0, 0, OPS));
        rows.push_back(r(STR, 2'b10, 1, 0, OPS));
      end
      foreach (rows[i]) begin
        apply(rows[i]);
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
        total++;
        if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    tname = "illegal";
    do_reset();
    rows.delete();
    rows.push_back(r(SF, 0, 1, 0, OPX)); rows.push_back(r(SD, 0, 1, 0, OPX));
    for (int k = 0; k < 20; k++) rows.push_back(r(STR, 2'b01, k[0], k[1], (k[2] ? OPR : OPX)));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
    // Reset is asynchronous: the trap must clear before any clock edge.
    mem_ready = 1'b1; stall = 1'b0; op = OPR;
    rst_n = 1'b0;
    #2;
    total++;
    if (obs1 !== model(SF, 1'b1, 1'b0, 2'b00)) begin
      bad++; $display("FAIL trap_async_reset got=%h exp=%h", obs1, model(SF, 1'b1, 1'b0, 2'b00));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tname = "after_trap";
    rows.delete();
    rows.push_back(r(SF, 0, 1, 0, OPR)); rows.push_back(r(SD, 0, 1, 0, OPR));
    rows.push_back(r(SER, 0, 1, 0, OPR));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jalr_lui();
    exp_t e;
    tname = "jalr_lui";
    do_reset();
    rows.delete();
    rows.push_back(r(SF, 0, 1, 0, OPJR)); rows.push_back(r(SD, 0, 1, 0, OPJR));
    rows.push_back(r(SMA, 0, 1, 0, OPJR)); rows.push_back(r(SJ, 0, 1, 0, OPJR));
    rows.push_back(r(SAW, 0, 1, 0, OPJR));
    rows.push_back(r(SF, 0, 1, 0, OPU)); rows.push_back(r(SD, 0, 1, 0, OPU));
    rows.push_back(r2(SLU, 0, STR, 2'b01, OPU)); rows.push_back(r2(SAW, 0, STR, 2'b01, OPU));
    rows.push_back(r2(SF, 0, STR, 2'b01, OPU)); rows.push_back(r2(SD, 0, STR, 2'b01, OPU));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_execi_stall();
    exp_t e;
    tname = "execi_stall";
    do_reset();
    rows.delete();
    rows.push_back(r(SF, 0, 1, 0, OPI));  rows.push_back(r(SD, 0, 1, 0, OPI));
    rows.push_back(r(SEI, 0, 1, 1, OPI)); rows.push_back(r(SEI, 0, 1, 1, OPI));
    rows.push_back(r(SEI, 0, 1, 0, OPI)); rows.push_back(r(SAW, 0, 1, 1, OPI));
    rows.push_back(r(SAW, 0, 1, 0, OPI)); rows.push_back(r(SF, 0, 1, 0, OPI));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    tname = "back_to_back";
    do_reset();
    rows.delete();
    rows.push_back(r(SF, 0, 1, 0, OPA)); rows.push_back(r(SD, 0, 1, 0, OPA));
    rows.push_back(r(SAU, 0, 1, 0, OPA)); rows.push_back(r(SAW, 0, 1, 0, OPA));
    rows.push_back(r(SF, 0, 1, 0, OPB)); rows.push_back(r(SD, 0, 1, 0, OPB));
    rows.push_back(r(SBR, 0, 1, 1, OPB)); rows.push_back(r(SBR, 0, 1, 0, OPB));
    rows.push_back(r(SF, 0, 1, 0, OPJ)); rows.push_back(r(SD, 0, 1, 0, OPJ));
    rows.push_back(r(SJ, 0, 1, 1, OPJ)); rows.push_back(r(SJ, 0, 1, 0, OPJ));
    rows.push_back(r(SAW, 0, 1, 0, OPJ)); rows.push_back(r(SF, 0, 0, 0, OPJ));
    foreach (rows[i]) begin
      apply(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs1 !== e.e1) begin bad++; $display("FAIL %s row%0d main got=%h exp=%h", tname, i, obs1, e.e1); end
      total++;
      if (obs2 !== e.e2) begin bad++; $display("FAIL %s row%0d nolui got=%h exp=%h", tname, i, obs2, e.e2); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; op = 7'd0; mem_ready = 1'b0; stall = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_stall();
    test_timeout();
    test_illegal();
    test_jalr_lui();
    test_execi_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
